// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector feeder path: FSM state encodings
// and the default serial word width.
package seq_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } seq_state_e;

   localparam int SEQ_WORD_W = 8;

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Parallel-in / serial-out bundle between an upstream word source (master)
// and the bit serializer (slave).
interface seq_bit_serializer_if
   import seq_pkg::*;
#(
   parameter int WIDTH = SEQ_WORD_W
) ();

   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             ser_out;
   logic             ser_valid;
   logic             last_bit;
   logic             busy;

   modport master (
      output din, din_valid,
      input  din_ready, ser_out, ser_valid, last_bit, busy
   );

   modport slave (
      input  din, din_valid,
      output din_ready, ser_out, ser_valid, last_bit, busy
   );

endinterface

// File: rtl/seq_hold_buf.sv
// One-entry holding register for the next word. ready_q is kept as its own flop
// so the upstream ready signal never passes through logic.
module seq_hold_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             buf_valid,
   output logic             ready
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ready_q, ready_d;

   // Next-state for the entry; pop and write never coincide because a write
   // needs ready, which is low while the entry is occupied.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (pop) begin
         valid_d = 1'b0;
      end else if (wr) begin
         data_d  = wdata;
         valid_d = 1'b1;
      end else begin
         valid_d = valid_q;
      end
      ready_d = ~valid_d;
   end

   // Entry storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= {WIDTH{1'b0}};
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
      end
   end

   assign rdata     = data_q;
   assign buf_valid = valid_q;
   assign ready     = ready_q;

endmodule

// File: rtl/seq_bit_serializer.sv
// Word-to-bit serializer feeding the sequence detector. A holding buffer keeps
// back-to-back words gapless; every output is taken straight from a flop.
module seq_bit_serializer
   import seq_pkg::*;
#(
   parameter int   WIDTH     = SEQ_WORD_W,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seq_bit_serializer_if.slave  bus
);

   localparam int             CW        = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST_CNT  = CW'(WIDTH - 1);
   localparam int             OUT_IDX   = MSB_FIRST ? WIDTH - 1 : 0;
   localparam logic [WIDTH-1:0] IDLE_WORD = {WIDTH{IDLE_BIT}};

   seq_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;

   logic             accept_s, last_s, wr_s, pop_s;
   logic             buf_valid_s, ready_s;
   logic [WIDTH-1:0] buf_data_s;

   seq_hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr        (wr_s),
      .pop       (pop_s),
      .wdata     (bus.din),
      .rdata     (buf_data_s),
      .buf_valid (buf_valid_s),
      .ready     (ready_s)
   );

   assign accept_s = bus.din_valid & ready_s;
   assign last_s   = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);

   // Next state, counter and shift register. Going idle refills the shift
   // register with IDLE_BIT so ser_out can stay a plain flop output.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      wr_s    = 1'b0;
      pop_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_SHIFT;
               cnt_d   = {CW{1'b0}};
               shreg_d = bus.din;
            end else begin
               shreg_d = IDLE_WORD;
            end
         end
         ST_SHIFT: begin
            if (!last_s) begin
               cnt_d = cnt_q + CW'(1);
               wr_s  = accept_s;
               if (MSB_FIRST) begin
                  shreg_d = {shreg_q[WIDTH-2:0], IDLE_BIT};
               end else begin
                  shreg_d = {IDLE_BIT, shreg_q[WIDTH-1:1]};
               end
            end else if (buf_valid_s) begin
               pop_s   = 1'b1;
               cnt_d   = {CW{1'b0}};
               shreg_d = buf_data_s;
            end else if (accept_s) begin
               cnt_d   = {CW{1'b0}};
               shreg_d = bus.din;
            end else begin
               state_d = ST_IDLE;
               cnt_d   = {CW{1'b0}};
               shreg_d = IDLE_WORD;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {CW{1'b0}};
            shreg_d = IDLE_WORD;
         end
      endcase
      last_d = (state_d == ST_SHIFT) && (cnt_d == LAST_CNT);
      busy_d = (state_d == ST_SHIFT) | wr_s | (buf_valid_s & ~pop_s);
   end

   // FSM, counter, shift register and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CW{1'b0}};
         shreg_q <= IDLE_WORD;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.ser_out   = shreg_q[OUT_IDX];
   assign bus.ser_valid = (state_q == ST_SHIFT);
   assign bus.last_bit  = last_q;
   assign bus.busy      = busy_q;
   assign bus.din_ready = ready_s;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: a vector table for gapless streaming
// plus hand-written sequences for reset, widths, bit order, idle level and timing.
module tb_seq_bit_serializer;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   seq_bit_serializer_if #(.WIDTH(8)) if8 ();
   seq_bit_serializer_if #(.WIDTH(5)) if5 ();
   seq_bit_serializer_if #(.WIDTH(8)) ifl ();
   seq_bit_serializer_if #(.WIDTH(8)) ifi ();

   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u8  (.clk(clk), .rst_n(rst_n), .bus(if8));
   seq_bit_serializer #(.WIDTH(5), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u5  (.clk(clk), .rst_n(rst_n), .bus(if5));
   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) ulsb (.clk(clk), .rst_n(rst_n), .bus(ifl));
   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) uidl (.clk(clk), .rst_n(rst_n), .bus(ifi));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] din;
      logic       vld;
      logic       so;
      logic       sv;
      logic       last;
      logic       rdy;
      logic       busy;
   } vec_t;

   vec_t tbl [17];

   function automatic vec_t mk(logic [7:0] d, logic v, logic so, logic sv,
                               logic l, logic r, logic b);
      vec_t t;
      t.din = d; t.vld = v; t.so = so; t.sv = sv; t.last = l; t.rdy = r; t.busy = b;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0]  w;
      logic [4:0]  w5;
      logic [15:0] stream;
      tests = 0;
      fails = 0;

      // 8'hF0 then 8'h0F with din_valid held; 8'h33 offered while not ready must be ignored.
      tbl[0]  = mk(8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      tbl[1]  = mk(8'h0F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      tbl[2]  = mk(8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      tbl[3]  = mk(8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      tbl[4]  = mk(8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      tbl[5]  = mk(8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      tbl[6]  = mk(8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      tbl[7]  = mk(8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      tbl[8]  = mk(8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      tbl[9]  = mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      tbl[10] = mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      tbl[11] = mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      tbl[12] = mk(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      tbl[13] = mk(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      tbl[14] = mk(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      tbl[15] = mk(8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tbl[16] = mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      rst_n = 1'b0;
      if8.din = 8'h00; if8.din_valid = 1'b0;
      if5.din = 5'h00; if5.din_valid = 1'b0;
      ifl.din = 8'h00; ifl.din_valid = 1'b0;
      ifi.din = 8'h00; ifi.din_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step();

      check("rst8.ser_valid", 32'(if8.ser_valid), 32'd0);
      check("rst8.ser_out",   32'(if8.ser_out),   32'd0);
      check("rst8.din_ready", 32'(if8.din_ready), 32'd1);
      check("rst8.busy",      32'(if8.busy),      32'd0);
      check("rst8.last_bit",  32'(if8.last_bit),  32'd0);
      check("rst5.din_ready", 32'(if5.din_ready), 32'd1);
      check("idle1.ser_out",  32'(ifi.ser_out),   32'd1);
      check("idle1.ser_valid",32'(ifi.ser_valid), 32'd0);

      // Gapless back-to-back streaming from the vector table.
      stream = 16'h0000;
      for (int i = 0; i < 17; i++) begin
         if8.din       = tbl[i].din;
         if8.din_valid = tbl[i].vld;
         step();
         check($sformatf("tbl[%0d].ser_out", i),   32'(if8.ser_out),   32'(tbl[i].so));
         check($sformatf("tbl[%0d].ser_valid", i), 32'(if8.ser_valid), 32'(tbl[i].sv));
         check($sformatf("tbl[%0d].last_bit", i),  32'(if8.last_bit),  32'(tbl[i].last));
         check($sformatf("tbl[%0d].din_ready", i), 32'(if8.din_ready), 32'(tbl[i].rdy));
         check($sformatf("tbl[%0d].busy", i),      32'(if8.busy),      32'(tbl[i].busy));
         if (if8.ser_valid) stream = {stream[14:0], if8.ser_out};
      end
      if8.din_valid = 1'b0;
      check("b2b.stream", 32'(stream), 32'h0000F00F);

      // Reset mid-word, then the next word must start from its first bit.
      if8.din = 8'hA5; if8.din_valid = 1'b1;
      step();
      if8.din_valid = 1'b0;
      check("mid.first_bit", 32'(if8.ser_out), 32'd1);
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      check("arst.ser_valid", 32'(if8.ser_valid), 32'd0);
      check("arst.ser_out",   32'(if8.ser_out),   32'd0);
      check("arst.din_ready", 32'(if8.din_ready), 32'd1);
      check("arst.busy",      32'(if8.busy),      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("post_rst.ser_valid", 32'(if8.ser_valid), 32'd0);
      w = 8'h3C;
      if8.din = w; if8.din_valid = 1'b1;
      step();
      if8.din_valid = 1'b0;
      for (int j = 0; j < 8; j++) begin
         check($sformatf("post_rst.bit%0d", j), 32'(if8.ser_out), 32'(w[7-j]));
         check($sformatf("post_rst.vld%0d", j), 32'(if8.ser_valid), 32'd1);
         step();
      end
      check("post_rst.idle", 32'(if8.ser_valid), 32'd0);

      // WIDTH=5 single word, MSB first.
      w5 = 5'b11011;
      if5.din = w5; if5.din_valid = 1'b1;
      step();
      if5.din_valid = 1'b0;
      for (int j = 0; j < 5; j++) begin
         check($sformatf("w5.bit%0d", j),  32'(if5.ser_out),   32'(w5[4-j]));
         check($sformatf("w5.vld%0d", j),  32'(if5.ser_valid), 32'd1);
         check($sformatf("w5.last%0d", j), 32'(if5.last_bit),  32'(j == 4));
         step();
      end
      check("w5.end_valid", 32'(if5.ser_valid), 32'd0);
      check("w5.end_out",   32'(if5.ser_out),   32'd0);
      check("w5.end_busy",  32'(if5.busy),      32'd0);

      // LSB first.
      w = 8'h01;
      ifl.din = w; ifl.din_valid = 1'b1;
      step();
      ifl.din_valid = 1'b0;
      for (int j = 0; j < 8; j++) begin
         check($sformatf("lsb.bit%0d", j), 32'(ifl.ser_out), 32'(w[j]));
         step();
      end
      check("lsb.end_valid", 32'(ifl.ser_valid), 32'd0);

      // IDLE_BIT=1: idle level restored right after the last bit.
      w = 8'h5A;
      ifi.din = w; ifi.din_valid = 1'b1;
      step();
      ifi.din_valid = 1'b0;
      for (int j = 0; j < 8; j++) begin
         check($sformatf("idl.bit%0d", j),  32'(ifi.ser_out),  32'(w[7-j]));
         check($sformatf("idl.last%0d", j), 32'(ifi.last_bit), 32'(j == 7));
         step();
      end
      check("idl.end_out",   32'(ifi.ser_out),   32'd1);
      check("idl.end_valid", 32'(ifi.ser_valid), 32'd0);

      // Late arrival in the last_bit cycle loads directly with no bubble.
      w = 8'hC3;
      if8.din = w; if8.din_valid = 1'b1;
      step();
      if8.din_valid = 1'b0;
      for (int j = 0; j < 8; j++) begin
         check($sformatf("late.a.bit%0d", j), 32'(if8.ser_out), 32'(w[7-j]));
         check($sformatf("late.a.last%0d", j), 32'(if8.last_bit), 32'(j == 7));
         if (j == 7) begin
            if8.din = 8'h5A; if8.din_valid = 1'b1;
         end
         step();
      end
      if8.din_valid = 1'b0;
      w = 8'h5A;
      for (int j = 0; j < 8; j++) begin
         check($sformatf("late.b.vld%0d", j), 32'(if8.ser_valid), 32'd1);
         check($sformatf("late.b.bit%0d", j), 32'(if8.ser_out),   32'(w[7-j]));
         check($sformatf("late.b.rdy%0d", j), 32'(if8.din_ready), 32'd1);
         step();
      end
      // One cycle late: exactly one idle bit before the next word.
      check("late.gap_valid", 32'(if8.ser_valid), 32'd0);
      check("late.gap_busy",  32'(if8.busy),      32'd0);
      if8.din = 8'hFF; if8.din_valid = 1'b1;
      step();
      if8.din_valid = 1'b0;
      check("late.c.vld0", 32'(if8.ser_valid), 32'd1);
      check("late.c.bit0", 32'(if8.ser_out),   32'd1);
      repeat (8) step();
      check("late.c.end_valid", 32'(if8.ser_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
